// File: rtl/widths_serializer.sv
// Splits a packed {field_a, field_b} word into CHUNK_W-bit chunks, least significant chunk first,
// with valid/ready handshakes on both sides and back-to-back word streaming.
module widths_serializer #(
    parameter int WIDTH_A = 5,
    parameter int WIDTH_B = 3,
    parameter int CHUNK_W = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A+WIDTH_B-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHUNK_W-1:0]         out_data,
    output logic                       out_last,
    output logic                       busy
);
    // state | meaning
    // IDLE  | no word held, ready for a new one
    // SHIFT | word held in r_shift, r_k is the index of the chunk on out_data

    localparam int IN_W   = WIDTH_A + WIDTH_B;
    localparam int NCHUNK = (CHUNK_W >= 1) ? IN_W / CHUNK_W : 1;
    localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [K_W-1:0] LAST_K = K_W'(NCHUNK - 1);

    generate
        if (CHUNK_W < 1) begin : g_bad_chunk
            $error("widths_serializer: CHUNK_W must be at least 1");
        end
        if ((CHUNK_W >= 1) && ((IN_W % CHUNK_W) != 0)) begin : g_bad_split
            $error("widths_serializer: WIDTH_A+WIDTH_B must be a multiple of CHUNK_W");
        end
    endgenerate

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t            r_state;
    logic [IN_W-1:0]   r_shift;
    logic [K_W-1:0]    r_k;
    logic              w_at_last;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign w_at_last  = (r_k == LAST_K);
    assign out_valid  = (r_state == SHIFT);
    assign busy       = out_valid;
    assign out_data   = r_shift[CHUNK_W-1:0];
    assign out_last   = out_valid && w_at_last;

    // A new word may enter in the same cycle the last chunk leaves, so streaming has no bubble.
    assign in_ready   = rst_n && ((r_state == IDLE) || (w_at_last && out_ready));
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_k     <= '0;
        end else if (w_in_xfer) begin
            r_state <= SHIFT;
            r_shift <= in_data;
            r_k     <= '0;
        end else if (w_out_xfer) begin
            if (w_at_last) begin
                r_state <= IDLE;
            end else begin
                r_shift <= r_shift >> CHUNK_W;
                r_k     <= r_k + K_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_widths_serializer.sv
// Directed bench for widths_serializer: default 2-bit chunking plus an 8-bit-chunk (one chunk per word) instance.
module tb_widths_serializer;
    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [7:0] in_data;
    logic [1:0] out_data;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, out_last8, busy8;
    logic [7:0] in_data8, out_data8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    widths_serializer u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    widths_serializer #(.WIDTH_A(5), .WIDTH_B(3), .CHUNK_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_last(out_last8), .busy(busy8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_chunk(input string tag, input logic [1:0] d, input logic l);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_last"},  32'(out_last),  32'(l));
    endtask

    task automatic chk_idle_outputs(input string tag, input logic rdy);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_last"},  32'(out_last),  32'd0);
        chk({tag, "_ready"}, 32'(in_ready),  32'(rdy));
    endtask

    initial begin
        logic [1:0] stream [8];
        stream = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};

        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hB4; out_ready = 1'b1;
        in_valid8 = 1'b0; in_data8 = 8'h00; out_ready8 = 1'b1;

        // Reset holds everything low, even with a word offered
        #2;
        chk_idle_outputs("rst", 1'b0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ready8", 32'(in_ready8), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_idle_outputs("post_rst", 1'b1);

        // Single word 8'hB4 -> 0,1,3,2
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hB4; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk_chunk("w1_c0", 2'd0, 1'b0);
        chk("w1_c0_ready", 32'(in_ready), 32'd0);
        @(negedge clk); chk_chunk("w1_c1", 2'd1, 1'b0);
        @(negedge clk); chk_chunk("w1_c2", 2'd3, 1'b0);
        @(negedge clk); chk_chunk("w1_c3", 2'd2, 1'b1);
        chk("w1_c3_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk_idle_outputs("w1_done", 1'b1);

        // Back-to-back B4 then 5A; 5A is offered early and must be ignored until the last chunk
        in_valid = 1'b1; in_data = 8'hB4;
        @(negedge clk);
        in_data = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            chk_chunk($sformatf("b2b_%0d", i), stream[i], (i == 3) || (i == 7));
            chk($sformatf("b2b_%0d_ready", i), 32'(in_ready), 32'((i == 3) || (i == 7)));
            if (i == 7) in_valid = 1'b0;
        end
        @(negedge clk);
        chk_idle_outputs("b2b_done", 1'b1);

        // Backpressure after chunk 1 for three cycles; offered data during the stall is ignored
        in_valid = 1'b1; in_data = 8'hB4;
        @(negedge clk);
        in_valid = 1'b0;
        chk_chunk("bp_c0", 2'd0, 1'b0);
        @(negedge clk);
        chk_chunk("bp_c1", 2'd1, 1'b0);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_chunk($sformatf("bp_hold%0d", i), 2'd1, 1'b0);
            chk($sformatf("bp_hold%0d_ready", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk); chk_chunk("bp_c2", 2'd3, 1'b0);
        @(negedge clk); chk_chunk("bp_c3", 2'd2, 1'b1);
        @(negedge clk);
        chk_idle_outputs("bp_done", 1'b1);

        // Reset mid-word discards the held word
        in_valid = 1'b1; in_data = 8'hB4;
        @(negedge clk);
        in_valid = 1'b0;
        chk_chunk("mr_c0", 2'd0, 1'b0);
        @(negedge clk);
        chk_chunk("mr_c1", 2'd1, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk_idle_outputs("mr_rst", 1'b0);
        chk("mr_rst_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("mr_after", 1'b1);
        chk("mr_after_data", 32'(out_data), 32'd0);
        in_valid = 1'b1; in_data = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        chk_chunk("mr_n0", 2'd2, 1'b0);
        @(negedge clk); chk_chunk("mr_n1", 2'd2, 1'b0);
        @(negedge clk); chk_chunk("mr_n2", 2'd1, 1'b0);
        @(negedge clk); chk_chunk("mr_n3", 2'd1, 1'b1);
        @(negedge clk);
        chk_idle_outputs("mr_done", 1'b1);

        // One chunk per word: a register slice with in_ready following out_ready while busy
        in_valid8 = 1'b1; in_data8 = 8'hC3; out_ready8 = 1'b1;
        @(negedge clk);
        chk("c8_a_valid", 32'(out_valid8), 32'd1);
        chk("c8_a_data",  32'(out_data8),  32'hC3);
        chk("c8_a_last",  32'(out_last8),  32'd1);
        chk("c8_a_ready", 32'(in_ready8),  32'd1);
        in_data8 = 8'h3C;
        @(negedge clk);
        chk("c8_b_data", 32'(out_data8), 32'h3C);
        chk("c8_b_last", 32'(out_last8), 32'd1);
        out_ready8 = 1'b0; in_data8 = 8'h77;
        #1;
        chk("c8_stall_ready", 32'(in_ready8), 32'd0);
        @(negedge clk);
        chk("c8_stall_data",  32'(out_data8),  32'h3C);
        chk("c8_stall_valid", 32'(out_valid8), 32'd1);
        out_ready8 = 1'b1; in_valid8 = 1'b0;
        #1;
        chk("c8_resume_ready", 32'(in_ready8), 32'd1);
        @(negedge clk);
        chk("c8_done_valid", 32'(out_valid8), 32'd0);
        chk("c8_done_busy",  32'(busy8),      32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/widths_serializer.md
WIDTHS_SERIALIZER -- requirements
Module: widths_serializer

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH_A, 5, width of upper field of the packed input word
- WIDTH_B, 3, width of lower field of the packed input word
- CHUNK_W, 2, width of each output chunk
REQ-002 Derived constants SHALL be IN_W = WIDTH_A+WIDTH_B and NCHUNK = IN_W/CHUNK_W; elaboration SHALL fail if IN_W is not a multiple of CHUNK_W or CHUNK_W < 1.
REQ-003 Ports SHALL be, one per line:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  packed word offered
- in_ready  output  1  block accepts word this cycle
- in_data  input  IN_W  packed word {field_a, field_b}, field_b in LSBs
- out_valid  output  1  chunk presented
- out_ready  input  1  consumer takes chunk this cycle
- out_data  output  CHUNK_W  current chunk
- out_last  output  1  current chunk is chunk NCHUNK-1 of its word
- busy  output  1  word held (state SHIFT)
REQ-004 The design SHALL have one clock; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-005 Input transfer SHALL occur on a rising edge with in_valid && in_ready; output transfer on a rising edge with out_valid && out_ready.
REQ-006 State machine SHALL have two states: IDLE (no word held) and SHIFT (word held, chunk index k in 0..NCHUNK-1).
REQ-007 IDLE -> SHIFT on input transfer; data captured into holding shift register, k = 0.
REQ-008 In SHIFT, output transfer with k < NCHUNK-1 SHALL shift register right by CHUNK_W and increment k.
REQ-009 In SHIFT, output transfer with k = NCHUNK-1 SHALL go to IDLE, unless an input transfer occurs in the same cycle, in which case the new word is loaded, k = 0, and state stays SHIFT (no bubble).
REQ-010 in_ready SHALL equal (state==IDLE) || (state==SHIFT && k==NCHUNK-1 && out_ready), gated low while rst_n is low; the out_ready -> in_ready combinational path is intended.
REQ-011 out_valid SHALL equal (state==SHIFT); busy SHALL equal out_valid.
REQ-012 out_data SHALL be the CHUNK_W LSBs of the holding register; chunk order is LSB first (field_b bits leave first).
REQ-013 out_last SHALL be 1 iff out_valid and k==NCHUNK-1.
REQ-014 While out_valid && !out_ready, out_data, out_last and k SHALL remain stable.
REQ-015 Latency: first chunk SHALL be valid the cycle after input transfer; with out_ready held high, a word SHALL take exactly NCHUNK cycles and consecutive words SHALL stream without idle cycles.
REQ-016 k SHALL be $clog2(NCHUNK) bits, minimum 1; it SHALL wrap to 0 only via a new load, never by overflow.
REQ-017 NCHUNK = 1 SHALL be supported: every chunk has out_last=1, behaving as a one-deep register slice.
REQ-018 in_valid while in_ready is low SHALL have no effect; in_data SHALL be sampled only on input transfer.

Reset
REQ-019 When rst_n is low, asynchronously: state IDLE, k=0, holding register 0, out_valid=0, out_last=0, busy=0, out_data=0, in_ready=0.
REQ-020 After rst_n rises, the first rising edge SHALL see in_ready=1; reset mid-word SHALL discard the held word with no partial chunks afterwards.

Verification
REQ-021 Defaults, in_data=8'hB4, out_ready=1 -> out_data 0,1,3,2 on four consecutive cycles, out_last only on the 4th, then out_valid=0.
REQ-022 Back-to-back 8'hB4 then 8'h5A, in_valid and out_ready held 1 -> out_data 0,1,3,2,2,2,1,1 with no gap, in_ready high on the 4th cycle, out_last on the 4th and 8th.
REQ-023 8'hB4 with out_ready low for 3 cycles after chunk 1 -> out_data=1 and k frozen for those 3 cycles, in_ready=0, then 3,2 follow.
REQ-024 rst_n pulsed low after chunk 1 of 8'hB4 -> all outputs 0 immediately, no further chunks, next word 8'h5A serializes as 2,2,1,1.
REQ-025 CHUNK_W=8 -> every accepted word appears whole with out_last=1; in_ready tracks out_ready while busy.
REQ-026 Elaborate WIDTH_A=5, WIDTH_B=3, CHUNK_W=3 -> elaboration error.
